sd_cmd_tx: RTL and testbench
============================

Name: sd_cmd_tx

Overview:
- Serializes one SD-bus command frame (48 bits, MSB first) onto the CMD line.
- Sits directly upstream of the CRC_7 generator. Feeds it the first 40 frame bits via its BITVAL/Enable inputs, then takes its 7-bit CRC output and appends it plus the end bit.
- One frame bit per CLK cycle; CLK is the SD-clock-domain clock.
- Upstream command controller uses a start/ready handshake.

Parameters:
- GAP_CYCLES, 8, idle cycles after end bit (CMD high, oe low) before ready reasserts; legal 0..63.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- start  input  1  request to send a frame; sampled only when ready=1.
- cmd_index  input  6  command index; captured with start.
- cmd_arg  input  32  command argument; captured with start.
- ready  output  1  idle, can accept start.
- done  output  1  one-cycle pulse during the end-bit cycle.
- cmd_out  output  1  registered CMD line data.
- cmd_oe  output  1  registered CMD output enable (1 = drive).
- crc_bit  output  1  to CRC_7 BITVAL.
- crc_en  output  1  to CRC_7 Enable.
- crc_in  input  7  from CRC_7 CRC.

Behaviour:
- Reset values: ready=1, done=0, cmd_out=1, cmd_oe=0, crc_bit=0, crc_en=0; state IDLE; counters 0.
- RST mid-frame aborts immediately. Next cycle the outputs hold their reset values, so CRC_7 clears because crc_en=0. No partial CRC or end bit is emitted.
- Frame bits 0..47:
  - bit0 = 0 (start)
  - bit1 = 1 (transmission)
  - bits2..7 = cmd_index[5:0]
  - bits8..39 = cmd_arg[31:0]
  - bits40..46 = CRC7 over bits0..39, MSB first
  - bit47 = 1 (end)
- Acceptance: start=1 and ready=1 at cycle T0. At that edge, capture a 40-bit body shift register and set ready=0. start while ready=0 is ignored.
- States: IDLE -> BODY (40 bits) -> CRC (7 bits) -> ENDB (1 bit) -> GAP (GAP_CYCLES) -> IDLE. GAP is skipped when GAP_CYCLES=0.
- crc_bit/crc_en lead cmd_out by one cycle (combinational from next-bit logic):
  - During T0..T39: crc_en=1 and crc_bit = frame bit k in cycle Tk.
  - crc_en=0 from T40 onward.
  - crc_en must be high for exactly 40 contiguous cycles. CRC_7 clears whenever Enable=0, so any gap corrupts the CRC.
- cmd_out = frame bit k during cycle T(k+1), k=0..47; cmd_oe=1 during T1..T48.
- crc_in is valid during T40, when cmd_out shows bit39. At the T40 edge:
  - crc_in[6] loads into cmd_out.
  - crc_in[5:0] latches into an internal CRC shift register.
  - Later edges shift the remaining bits out MSB first. crc_in is not sampled again, since CRC_7 has already cleared.
- ENDB: cmd_out=1, cmd_oe=1, done=1 during T48.
- GAP: cmd_out=1, cmd_oe=0 for GAP_CYCLES cycles. ready=1 from the cycle after the last GAP cycle; with GAP_CYCLES=0, from T49.
- Outside a frame: cmd_out=1, cmd_oe=0, crc_en=0.
- Back-to-back: start held high re-accepts on the first ready cycle. Minimum frame period is 49+GAP_CYCLES cycles.
- Inputs cmd_index/cmd_arg may change freely after acceptance.

Test Plan:
- Reset, then CMD0 (index 0, arg 0x00000000) -> cmd_out over T1..T48 = 0x400000000095 (CRC7=0x4A); cmd_oe high exactly 48 cycles; done at T48.
- CMD8, arg 0x000001AA -> serialized frame 0x48000001AA87 (CRC7=0x43); crc_en high exactly T0..T39.
- CMD17, arg 0 with GAP_CYCLES=8 and start held high -> second frame begins exactly 57 cycles after first acceptance; both frames 0x510000000055.
- start pulsed during CRC state of an active frame -> ignored; frame unchanged; ready stays 0 until gap ends.
- RST asserted at T20 of CMD0 -> next cycle cmd_oe=0, cmd_out=1, crc_en=0, ready=1. A new CMD0 then sends a correct 0x400000000095.
- GAP_CYCLES=0 -> ready=1 at T49; new frame start bit appears at T50 when start is held.

Source files
------------

// File: rtl/sd_cmd_tx.sv
// SD-bus command frame serializer: start/transmission bits, index, argument,
// CRC7 from an external CRC_7 block and end bit, MSB first, one bit per CLK.
module sd_cmd_tx #(
   parameter int unsigned GAP_CYCLES = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   output logic        ready,
   output logic        done,
   output logic        cmd_out,
   output logic        cmd_oe,
   output logic        crc_bit,
   output logic        crc_en,
   input  logic [6:0]  crc_in
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_BODY = 3'd1,
      S_CRC  = 3'd2,
      S_ENDB = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   localparam logic [5:0] GAP_LAST = 6'(GAP_CYCLES);

   state_t      state_q;
   logic [38:0] body_q;
   logic [5:0]  crc_q;
   logic [5:0]  cnt_q;
   logic        ready_q;
   logic        done_q;
   logic        cmd_out_q;
   logic        cmd_oe_q;
   logic        crc_en_s;
   logic        crc_bit_s;

   // CRC feed runs one bit ahead of cmd_out; the start bit is fed in the accept cycle.
   always_comb begin
      crc_en_s  = 1'b0;
      crc_bit_s = 1'b0;
      if (RST) begin
         crc_en_s  = 1'b0;
         crc_bit_s = 1'b0;
      end else if (state_q == S_IDLE) begin
         crc_en_s  = start;
         crc_bit_s = 1'b0;
      end else if (state_q == S_BODY) begin
         crc_en_s  = (cnt_q <= 6'd39);
         crc_bit_s = (cnt_q <= 6'd39) ? body_q[38] : 1'b0;
      end else begin
         crc_en_s  = 1'b0;
         crc_bit_s = 1'b0;
      end
   end

   // Frame sequencer with registered CMD line, enable, ready and done.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         body_q    <= 39'd0;
         crc_q     <= 6'd0;
         cnt_q     <= 6'd0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         cmd_out_q <= 1'b1;
         cmd_oe_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q   <= S_BODY;
                  ready_q   <= 1'b0;
                  body_q    <= {1'b1, cmd_index, cmd_arg};
                  cnt_q     <= 6'd1;
                  cmd_out_q <= 1'b0;
                  cmd_oe_q  <= 1'b1;
               end else begin
                  ready_q   <= 1'b1;
                  cmd_out_q <= 1'b1;
                  cmd_oe_q  <= 1'b0;
               end
            end
            S_BODY: begin
               // crc_in is only valid in the cycle after the last enabled bit.
               if (cnt_q == 6'd40) begin
                  cmd_out_q <= crc_in[6];
                  crc_q     <= crc_in[5:0];
                  cnt_q     <= 6'd1;
                  state_q   <= S_CRC;
               end else begin
                  cmd_out_q <= body_q[38];
                  body_q    <= {body_q[37:0], 1'b0};
                  cnt_q     <= cnt_q + 6'd1;
               end
            end
            S_CRC: begin
               if (cnt_q == 6'd7) begin
                  cmd_out_q <= 1'b1;
                  done_q    <= 1'b1;
                  cnt_q     <= 6'd0;
                  state_q   <= S_ENDB;
               end else begin
                  cmd_out_q <= crc_q[5];
                  crc_q     <= {crc_q[4:0], 1'b0};
                  cnt_q     <= cnt_q + 6'd1;
               end
            end
            S_ENDB: begin
               done_q    <= 1'b0;
               cmd_out_q <= 1'b1;
               cmd_oe_q  <= 1'b0;
               cnt_q     <= 6'd1;
               if (GAP_CYCLES == 32'd0) begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (cnt_q >= GAP_LAST) begin
                  ready_q <= 1'b1;
                  cnt_q   <= 6'd0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               ready_q   <= 1'b1;
               done_q    <= 1'b0;
               cmd_out_q <= 1'b1;
               cmd_oe_q  <= 1'b0;
               cnt_q     <= 6'd0;
            end
         endcase
      end
   end

   assign ready   = ready_q;
   assign done    = done_q;
   assign cmd_out = cmd_out_q;
   assign cmd_oe  = cmd_oe_q;
   assign crc_bit = crc_bit_s;
   assign crc_en  = crc_en_s;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Randomized bench for sd_cmd_tx: two instances (gap 8 and gap 0) with a
// frame-phase reference model and a CRC_7 stand-in each.
module tb_sd_cmd_tx;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  cmd_index = 6'd0;
   logic [31:0] cmd_arg = 32'd0;

   logic ready_a, done_a, cmd_out_a, cmd_oe_a, crc_bit_a, crc_en_a;
   logic ready_b, done_b, cmd_out_b, cmd_oe_b, crc_bit_b, crc_en_b;
   logic [6:0] crc_a = 7'd0;
   logic [6:0] crc_b = 7'd0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit run = 1'b0;

   int          ph[2] = '{-1, -1};
   int          gap[2] = '{8, 0};
   logic [47:0] frm[2];
   logic [47:0] cap[2];
   logic [47:0] last[2];
   int          t1[2] = '{0, 0};
   int          per[2] = '{0, 0};
   logic [5:0]  obs[2];
   logic [5:0]  e_v;

   sd_cmd_tx #(.GAP_CYCLES(8)) dut_a (
      .CLK(CLK), .RST(RST), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
      .ready(ready_a), .done(done_a), .cmd_out(cmd_out_a), .cmd_oe(cmd_oe_a),
      .crc_bit(crc_bit_a), .crc_en(crc_en_a), .crc_in(crc_a)
   );

   sd_cmd_tx #(.GAP_CYCLES(0)) dut_b (
      .CLK(CLK), .RST(RST), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
      .ready(ready_b), .done(done_b), .cmd_out(cmd_out_b), .cmd_oe(cmd_oe_b),
      .crc_bit(crc_bit_b), .crc_en(crc_en_b), .crc_in(crc_b)
   );

   assign obs[0] = {ready_a, done_a, cmd_out_a, cmd_oe_a, crc_bit_a, crc_en_a};
   assign obs[1] = {ready_b, done_b, cmd_out_b, cmd_oe_b, crc_bit_b, crc_en_b};

   always #5 CLK = ~CLK;

   function automatic logic [6:0] crc_next(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [47:0] build(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] body;
      logic [6:0]  c;
      body = {2'b01, idx, arg};
      c = 7'd0;
      for (int k = 39; k >= 0; k--) c = crc_next(c, body[k]);
      return {body, c, 1'b1};
   endfunction

   // Expected {ready, done, cmd_out, cmd_oe, crc_bit, crc_en} at frame phase p (-1 = idle).
   function automatic logic [5:0] expect_out(input int p, input logic [47:0] f, input logic st);
      logic ob, oe, dn, cb, ce;
      if (p < 0) return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, st};
      oe = (p <= 48);
      dn = (p == 48);
      ce = (p <= 39);
      ob = 1'b1;
      cb = 1'b0;
      if (p <= 48) ob = f[48-p];
      if (p <= 39) cb = f[47-p];
      return {1'b0, dn, ob, oe, cb, ce};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // CRC_7 stand-ins: clear whenever Enable is low.
   always @(posedge CLK) begin
      crc_a <= crc_en_a ? crc_next(crc_a, crc_bit_a) : 7'd0;
      crc_b <= crc_en_b ? crc_next(crc_b, crc_bit_b) : 7'd0;
   end

   // Reference model: frame phase advances per cycle from the accepting edge.
   always @(posedge CLK) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (RST) ph[i] = -1;
         else if (ph[i] < 0) begin
            if (start) begin
               ph[i] = 1;
               frm[i] = build(cmd_index, cmd_arg);
            end
         end else begin
            ph[i] = ph[i] + 1;
            if (ph[i] == 49 + gap[i]) ph[i] = -1;
         end
      end
   end

   always @(negedge CLK) begin
      if (run && !RST) begin
         for (int i = 0; i < 2; i++) begin
            e_v = expect_out(ph[i], frm[i], start);
            check(i == 0 ? "out_gap8" : "out_gap0", {58'd0, obs[i]}, {58'd0, e_v});
            if (ph[i] >= 1 && ph[i] <= 48) cap[i] = {cap[i][46:0], obs[i][3]};
            if (ph[i] == 1) begin
               per[i] = cyc - t1[i];
               t1[i] = cyc;
            end
            if (ph[i] == 48) begin
               last[i] = cap[i];
               check(i == 0 ? "frame_gap8" : "frame_gap0", {16'd0, cap[i]}, {16'd0, frm[i]});
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && !(ready_a && ready_b); i++) step();
      check("idle_wait", {62'd0, ready_a, ready_b}, 64'd3);
   endtask

   task automatic send(input logic [5:0] idx, input logic [31:0] arg);
      cmd_index = idx;
      cmd_arg = arg;
      start = 1'b1;
      step();
      start = 1'b0;
      cmd_index = 6'($urandom);
      cmd_arg = $urandom;
   endtask

   initial begin
      RST = 1'b1;
      repeat (3) step();
      RST = 1'b0;
      run = 1'b1;
      step();
      check("reset_a", {58'd0, obs[0]}, 64'h28);
      check("reset_b", {58'd0, obs[1]}, 64'h28);

      send(6'd0, 32'h0);
      wait_idle();
      check("cmd0", {16'd0, last[0]}, 64'h400000000095);

      send(6'd8, 32'h000001AA);
      wait_idle();
      check("cmd8", {16'd0, last[0]}, 64'h48000001AA87);
      check("cmd8_g0", {16'd0, last[1]}, 64'h48000001AA87);

      cmd_index = 6'd17;
      cmd_arg = 32'h0;
      start = 1'b1;
      repeat (58) step();
      start = 1'b0;
      wait_idle();
      check("cmd17", {16'd0, last[0]}, 64'h510000000055);
      check("period_gap8", 64'(per[0]), 64'd57);
      check("period_gap0", 64'(per[1]), 64'd49);

      send(6'd0, 32'h0);
      repeat (42) step();
      cmd_index = 6'h3F;
      cmd_arg = 32'hFFFFFFFF;
      start = 1'b1;
      step();
      start = 1'b0;
      check("busy_ready", {63'd0, ready_a}, 64'd0);
      wait_idle();
      check("crc_start_ign", {16'd0, last[0]}, 64'h400000000095);

      send(6'd0, 32'h0);
      repeat (19) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      check("abort", {60'd0, cmd_oe_a, cmd_out_a, crc_en_a, ready_a}, 64'h5);
      wait_idle();
      send(6'd0, 32'h0);
      wait_idle();
      check("cmd0_after_rst", {16'd0, last[0]}, 64'h400000000095);

      for (int n = 0; n < 1500; n++) begin
         start = ($urandom_range(0, 3) == 0);
         cmd_index = 6'($urandom);
         cmd_arg = $urandom;
         RST = ($urandom_range(0, 299) == 0);
         step();
      end
      RST = 1'b0;
      start = 1'b0;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
